// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin owner arbitration in front of one shared 8-input, DW-bit word
//   selector. A granted requester owns the datapath for a burst of up to
//   MAX_BURST beats. Its words are forwarded through a registered output stage.
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   req[7:0]   : request / continue-burst per requester
//   last[7:0]  : current beat of requester i is its final one
//   din        : packed words, requester i at din[i*DW +: DW]
//   ready      : downstream accepts a beat this cycle
//   gnt[7:0]   : one-hot grant to the current owner (zero when idle)
//   sel[2:0]   : binary index of the current/last owner
//   dout       : registered word from the owner
//   dout_valid : dout carries a new beat this cycle
//   busy       : arbiter is in the GRANT state
module mux_rr_arbiter #(
    parameter int DW        = 14,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      req,
    input  logic [7:0]      last,
    input  logic [8*DW-1:0] din,
    input  logic            ready,
    output logic [7:0]      gnt,
    output logic [2:0]      sel,
    output logic [DW-1:0]   dout,
    output logic            dout_valid,
    output logic            busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_n;
    logic [2:0]    ptr, ptr_n;
    logic [2:0]    owner, owner_n;
    logic [3:0]    beat_cnt, cnt_n;
    logic [DW-1:0] dout_n;
    logic          dv_n;

    // Rotate req so bit 0 corresponds to ptr; the lowest set bit of the
    // rotated vector is then the first requester in circular order.
    logic [15:0] req_dbl;
    logic [7:0]  req_rot;
    logic [2:0]  pick_off;
    logic [2:0]  pick;

    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[7:0];

    always_comb begin
        pick_off = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (req_rot[k]) pick_off = 3'(k);
        end
    end

    assign pick = ptr + pick_off;  // 3-bit add wraps 7 -> 0

    logic          beat;
    logic          release_now;
    logic [DW-1:0] owner_word;

    assign owner_word  = din[owner*DW +: DW];
    assign beat        = (state == GRANT) && req[owner] && ready;
    // Last-flag and burst cap landing on the same beat are one release.
    assign release_now = (state == GRANT) &&
                         (!req[owner] ||
                          (beat && (last[owner] || beat_cnt == 4'(MAX_BURST - 1))));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 3'd0;
            owner      <= 3'd0;
            beat_cnt   <= 4'd0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            owner      <= owner_n;
            beat_cnt   <= cnt_n;
            dout       <= dout_n;
            dout_valid <= dv_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        cnt_n   = beat_cnt;
        dout_n  = dout;
        dv_n    = 1'b0;
        case (state)
            IDLE: begin
                // Arbitration bubble: no beat moves in this cycle.
                if (req != 8'd0) begin
                    state_n = GRANT;
                    owner_n = pick;
                    cnt_n   = 4'd0;
                end
            end
            GRANT: begin
                if (beat) begin
                    dout_n = owner_word;
                    dv_n   = 1'b1;
                    cnt_n  = beat_cnt + 4'd1;
                end
                if (release_now) begin
                    state_n = IDLE;
                    ptr_n   = owner + 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // sel keeps the last owner after release; gnt/busy follow the state.
    assign busy = (state == GRANT);
    assign sel  = owner;
    assign gnt  = busy ? (8'd1 << owner) : 8'd0;

endmodule
